// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive controller.
// Holds the controller state encoding, the number of byte lanes per word
// and the width of the saturating overflow counter.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, CFG, RUN, RD, CAP, EMIT} state_t;
    localparam int WORD_BYTES = 4;
    localparam int OVF_W = 16;
endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: idle timer that saturates at TIMEOUT_CYCLES.
// Ports: clk_i/rst_i clock and async active-high reset; clear_i zeroes the
// count (wins over enable); enable_i advances it; reached_o is high while
// the count equals TIMEOUT_CYCLES.
module uart_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic reached_o
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear_i ? '0 : (enable_i && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign reached_o = cnt_q == LIMIT;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: configures the UART receiver baud rate and packs received
// bytes from its FIFO into up-to-4-byte words, flushing partial words after
// an idle timeout.
// Ports: CLKip/RSTi clock and async active-high reset; CFG_* baud request and
// sticky reject flag; BAUD_RATE* baud write to the receiver; RX_DONEi and
// FIFO_* receiver FIFO side; WORD_* packed-word handshake to downstream;
// OVF_CNTo saturating dropped-byte count; ACTIVEo high outside IDLE.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                        CLKip,
    input  logic                        RSTi,
    input  logic [31:0]                 CFG_BAUDi,
    input  logic                        CFG_STARTi,
    output logic                        CFG_ERRo,
    output logic [31:0]                 BAUD_RATEo,
    output logic                        BAUD_RATE_WEo,
    input  logic                        RX_DONEi,
    input  logic                        FIFO_EMPTYi,
    input  logic                        FIFO_FULLi,
    input  logic [DATA_WIDTH-1:0]       FIFO_DATAi,
    output logic                        FIFO_RDo,
    output logic [4*DATA_WIDTH-1:0]     WORD_DATAo,
    output logic [2:0]                  WORD_BYTESo,
    output logic                        WORD_VALIDo,
    input  logic                        WORD_READYi,
    output logic [OVF_W-1:0]            OVF_CNTo,
    output logic                        ACTIVEo
);
    localparam logic [31:0] BAUD_MAX = 32'(CLK_FREQ / 16);
    localparam logic [2:0] FULL_CNT = 3'(WORD_BYTES);

    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4*DATA_WIDTH-1:0] data_q, data_d;
    logic [31:0] baud_q, baud_d;
    logic err_q, err_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic baud_ok, cfg_win, to_reached;

    assign baud_ok = CFG_BAUDi != '0 && CFG_BAUDi <= BAUD_MAX;
    // Configuration requests are only honoured while idle or running.
    assign cfg_win = CFG_STARTi && (state_q == IDLE || state_q == RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: state_d = (CFG_STARTi && baud_ok) ? CFG : IDLE;
            CFG:  state_d = RUN;
            RUN: begin
                if (CFG_STARTi && baud_ok) begin
                    state_d = CFG;
                    cnt_d   = '0;
                    data_d  = '0;
                end else if (!FIFO_EMPTYi) state_d = RD;
                else if (to_reached && cnt_q != '0) state_d = EMIT;
            end
            RD:   state_d = CAP;
            CAP: begin
                data_d[cnt_q[1:0]*DATA_WIDTH +: DATA_WIDTH] = FIFO_DATAi;
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_d == FULL_CNT) ? EMIT : RUN;
            end
            EMIT: begin
                if (WORD_READYi) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    data_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        baud_d = (cfg_win && baud_ok) ? CFG_BAUDi : baud_q;
        err_d  = (cfg_win && !baud_ok) ? 1'b1 : (state_q == CFG) ? 1'b0 : err_q;
        ovf_d  = (RX_DONEi && FIFO_FULLi && !FIFO_RDo && ovf_q != '1) ? ovf_q + 1'b1 : ovf_q;
    end

    always_ff @(posedge CLKip or posedge RSTi) begin
        if (RSTi) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            baud_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            baud_q  <= baud_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // The idle timer only runs while a partial word is pending in RUN.
    uart_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i    (CLKip),
        .rst_i    (RSTi),
        .clear_i  (state_q == CAP || cnt_q == '0),
        .enable_i (state_q == RUN),
        .reached_o(to_reached)
    );

    assign BAUD_RATEo    = baud_q;
    assign BAUD_RATE_WEo = state_q == CFG;
    assign CFG_ERRo      = err_q;
    assign FIFO_RDo      = state_q == RD;
    assign WORD_VALIDo   = state_q == EMIT;
    assign WORD_DATAo    = data_q;
    assign WORD_BYTESo   = cnt_q;
    assign OVF_CNTo      = ovf_q;
    assign ACTIVEo       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with a small FIFO model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    localparam int T = 40;

    logic        CLKip = 1'b0;
    logic        RSTi = 1'b1;
    logic [31:0] CFG_BAUDi = '0;
    logic        CFG_STARTi = 1'b0;
    logic        CFG_ERRo;
    logic [31:0] BAUD_RATEo;
    logic        BAUD_RATE_WEo;
    logic        RX_DONEi = 1'b0;
    logic        FIFO_EMPTYi = 1'b1;
    logic        FIFO_FULLi = 1'b0;
    logic [7:0]  FIFO_DATAi = '0;
    logic        FIFO_RDo;
    logic [31:0] WORD_DATAo;
    logic [2:0]  WORD_BYTESo;
    logic        WORD_VALIDo;
    logic        WORD_READYi = 1'b1;
    logic [15:0] OVF_CNTo;
    logic        ACTIVEo;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0]  fifo_q[$];
    logic [34:0] exp_q[$];

    uart_rx_ctrl #(.CLK_FREQ(100_000_000), .DATA_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
        .CLKip(CLKip), .RSTi(RSTi), .CFG_BAUDi(CFG_BAUDi), .CFG_STARTi(CFG_STARTi),
        .CFG_ERRo(CFG_ERRo), .BAUD_RATEo(BAUD_RATEo), .BAUD_RATE_WEo(BAUD_RATE_WEo),
        .RX_DONEi(RX_DONEi), .FIFO_EMPTYi(FIFO_EMPTYi), .FIFO_FULLi(FIFO_FULLi),
        .FIFO_DATAi(FIFO_DATAi), .FIFO_RDo(FIFO_RDo), .WORD_DATAo(WORD_DATAo),
        .WORD_BYTESo(WORD_BYTESo), .WORD_VALIDo(WORD_VALIDo), .WORD_READYi(WORD_READYi),
        .OVF_CNTo(OVF_CNTo), .ACTIVEo(ACTIVEo)
    );

    always #5 CLKip = ~CLKip;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock; the FIFO model pops on a read strobe and presents the byte
    // during the following cycle.
    task automatic tick(input int n = 1);
        logic rd;
        repeat (n) begin
            rd = FIFO_RDo;
            @(posedge CLKip);
            #1;
            if (rd && fifo_q.size() != 0) FIFO_DATAi = fifo_q.pop_front();
            FIFO_EMPTYi = fifo_q.size() == 0;
        end
    endtask

    task automatic cfg(input logic [31:0] b);
        CFG_BAUDi = b;
        CFG_STARTi = 1'b1;
        tick();
        CFG_STARTi = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        FIFO_EMPTYi = 1'b0;
    endtask

    always @(negedge CLKip) begin
        if (!RSTi && WORD_VALIDo) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got data %0h bytes %0d, expected no word", WORD_DATAo, WORD_BYTESo);
            end else begin
                chk("word_data", WORD_DATAo, exp_q[0][31:0]);
                chk("word_bytes", WORD_BYTESo, exp_q[0][34:32]);
                if (WORD_READYi) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        tick(2);
        chk("rst_active", ACTIVEo, 0);
        chk("rst_baud", BAUD_RATEo, 0);
        chk("rst_we", BAUD_RATE_WEo, 0);
        chk("rst_valid", WORD_VALIDo, 0);
        chk("rst_rd", FIFO_RDo, 0);
        chk("rst_ovf", OVF_CNTo, 0);
        RSTi = 1'b0;
        tick();
        cfg(32'd0);
        chk("zero_baud_err", CFG_ERRo, 1);
        chk("zero_baud_we", BAUD_RATE_WEo, 0);
        chk("zero_baud_idle", ACTIVEo, 0);
        cfg(32'd10_000_000);
        chk("fast_baud_err", CFG_ERRo, 1);
        chk("fast_baud_we", BAUD_RATE_WEo, 0);
        chk("fast_baud_idle", ACTIVEo, 0);
        chk("fast_baud_val", BAUD_RATEo, 0);
        cfg(32'd115200);
        chk("cfg_we", BAUD_RATE_WEo, 1);
        chk("cfg_baud", BAUD_RATEo, 115200);
        chk("cfg_active", ACTIVEo, 1);
        tick();
        chk("run_we", BAUD_RATE_WEo, 0);
        chk("run_err_clr", CFG_ERRo, 0);
        chk("run_active", ACTIVEo, 1);
        cfg(32'd10_000_000);
        chk("run_bad_err", CFG_ERRo, 1);
        chk("run_bad_we", BAUD_RATE_WEo, 0);
        chk("run_bad_baud", BAUD_RATEo, 115200);
        chk("run_bad_active", ACTIVEo, 1);
        tick();
        chk("run_bad_we2", BAUD_RATE_WEo, 0);

        WORD_READYi = 1'b0;
        exp_q.push_back({3'd4, 32'h44332211});
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        tick();
        chk("rd_strobe", FIFO_RDo, 1);
        tick();
        chk("cap_no_rd", FIFO_RDo, 0);
        chk("cap_bytes", WORD_BYTESo, 0);
        tick();
        chk("lat_bytes", WORD_BYTESo, 1);
        chk("lat_data", WORD_DATAo, 32'h11);
        waited = 0;
        while (!WORD_VALIDo && waited < 20) begin tick(); waited++; end
        chk("full_valid", WORD_VALIDo, 1);
        CFG_BAUDi = 32'd9600;
        CFG_STARTi = 1'b1;
        tick();
        CFG_STARTi = 1'b0;
        chk("emit_cfg_we", BAUD_RATE_WEo, 0);
        chk("emit_cfg_baud", BAUD_RATEo, 115200);
        tick(4);
        chk("hold_valid", WORD_VALIDo, 1);
        WORD_READYi = 1'b1;
        tick();
        chk("post_valid", WORD_VALIDo, 0);
        chk("post_bytes", WORD_BYTESo, 0);
        chk("post_data", WORD_DATAo, 0);

        exp_q.push_back({3'd2, 32'h0000BBAA});
        push_byte(8'hAA);
        tick(3);
        push_byte(8'hBB);
        tick(T + 3);
        chk("to2_early", WORD_VALIDo, 0);
        tick();
        chk("to2_valid", WORD_VALIDo, 1);
        tick();
        chk("to2_done", WORD_VALIDo, 0);

        push_byte(8'h01);
        tick(3);
        push_byte(8'h02);
        tick(3);
        push_byte(8'h03);
        tick(2);
        chk("pre_rst_bytes", WORD_BYTESo, 2);
        #3 RSTi = 1'b1;
        #1;
        chk("arst_data", WORD_DATAo, 0);
        chk("arst_bytes", WORD_BYTESo, 0);
        chk("arst_active", ACTIVEo, 0);
        chk("arst_baud", BAUD_RATEo, 0);
        chk("arst_valid", WORD_VALIDo, 0);
        tick(2);
        RSTi = 1'b0;
        tick(T + 10);
        chk("rst_no_word", WORD_VALIDo, 0);
        cfg(32'd115200);
        tick();
        exp_q.push_back({3'd1, 32'h0000005A});
        push_byte(8'h5A);
        tick(T + 3);
        chk("to1_early", WORD_VALIDo, 0);
        tick();
        chk("to1_valid", WORD_VALIDo, 1);
        tick();
        chk("to1_done", WORD_VALIDo, 0);

        RX_DONEi = 1'b1;
        FIFO_FULLi = 1'b1;
        tick(3);
        chk("ovf_3", OVF_CNTo, 3);
        FIFO_FULLi = 1'b0;
        tick();
        chk("ovf_not_full", OVF_CNTo, 3);
        FIFO_FULLi = 1'b1;
        tick(65532);
        chk("ovf_max", OVF_CNTo, 16'hFFFF);
        tick(2);
        chk("ovf_sat", OVF_CNTo, 16'hFFFF);
        RX_DONEi = 1'b0;
        FIFO_FULLi = 1'b0;
        tick(2);
        chk("exp_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
